// File: rtl/gpio_edge_service_ctrl.sv
// gpio_edge_service_ctrl
//   Sole bus master for a 16-bit bidirectional GPIO slave (reg 0 data, 1 direction,
//   2 irq mask, 3 edge capture with write-1-to-clear). After reset, or when cfg_load
//   is pulsed, it programs direction and mask. It services the slave irq by reading
//   edge capture and clearing exactly the bits it read. Each serviced edge vector is
//   queued with a timestamp in a small FIFO. Data-register writes from a single
//   requester are arbitrated against irq service.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   gpio_address        register select to the slave
//   gpio_chipselect     access strobe
//   gpio_write_n        active-low write strobe
//   gpio_writedata      write data, zero-extended to 32 bits
//   gpio_readdata       registered read data, valid the cycle after the address
//   gpio_irq            slave interrupt (edge_capture & irq_mask)
//   cfg_dir, cfg_mask   values written by the configuration sequence
//   cfg_load            pulse: re-run configuration at the next idle point
//   out_req, out_data   data-register write request, held until out_ack
//   out_ack             one-cycle pulse on the cycle the data write is issued
//   evt_valid/ready     event FIFO handshake (pop when both high)
//   evt_data            {timestamp, edge vector} at the FIFO head, 0 when empty
//   evt_count           FIFO occupancy
//   busy                sequencer is not idle

module gpio_edge_service_ctrl #(
  parameter int unsigned GPIO_WIDTH = 16,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [1:0]                     gpio_address,
  output logic                           gpio_chipselect,
  output logic                           gpio_write_n,
  output logic [31:0]                    gpio_writedata,
  input  logic [31:0]                    gpio_readdata,
  input  logic                           gpio_irq,
  input  logic [GPIO_WIDTH-1:0]          cfg_dir,
  input  logic [GPIO_WIDTH-1:0]          cfg_mask,
  input  logic                           cfg_load,
  input  logic                           out_req,
  input  logic [GPIO_WIDTH-1:0]          out_data,
  output logic                           out_ack,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [TS_WIDTH+GPIO_WIDTH-1:0] evt_data,
  output logic [$clog2(FIFO_DEPTH):0]    evt_count,
  output logic                           busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = TS_WIDTH + GPIO_WIDTH;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  typedef enum logic [2:0] {
    StCfgDir,
    StCfgMask,
    StIdle,
    StRdAddr,
    StRdData,
    StClr,
    StWrOut
  } state_e;

  state_e state_q, state_d;

  // Low only for the first cycle out of reset so the bus is quiet while reset is
  // asserted; the direction write then appears on the first cycle after release.
  logic armed_q;

  logic                  cfg_pend_q, cfg_pend_d;
  // Suppresses irq sampling for the idle cycle right after a clear, because the
  // slave irq may still reflect the bits just cleared.
  logic                  hold_q, hold_d;
  logic [GPIO_WIDTH-1:0] cap_q, cap_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic [TS_WIDTH-1:0]   ts_cap_q, ts_cap_d;

  logic                  push;
  logic                  push_en;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;

  logic                  unused_readdata_hi;
  assign unused_readdata_hi = ^gpio_readdata[31:GPIO_WIDTH];

  // ---------------------------------------------------------------------------
  // Free-running timestamp
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StCfgDir;
      armed_q    <= 1'b0;
      cfg_pend_q <= 1'b0;
      hold_q     <= 1'b0;
      cap_q      <= '0;
      ts_cap_q   <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      cfg_pend_q <= cfg_pend_d;
      hold_q     <= hold_d;
      cap_q      <= cap_d;
      ts_cap_q   <= ts_cap_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cfg_pend_d      = cfg_pend_q | cfg_load;
    hold_d          = 1'b0;
    cap_d           = cap_q;
    ts_cap_d        = ts_cap_q;
    gpio_chipselect = 1'b0;
    gpio_write_n    = 1'b1;
    gpio_address    = ADDR_DATA;
    gpio_writedata  = '0;
    out_ack         = 1'b0;
    push            = 1'b0;

    unique case (state_q)
      StCfgDir: begin
        if (armed_q) begin
          gpio_chipselect = 1'b1;
          gpio_write_n    = 1'b0;
          gpio_address    = ADDR_DIR;
          gpio_writedata  = 32'(cfg_dir);
          state_d         = StCfgMask;
        end
      end
      StCfgMask: begin
        gpio_chipselect = 1'b1;
        gpio_write_n    = 1'b0;
        gpio_address    = ADDR_MASK;
        gpio_writedata  = 32'(cfg_mask);
        state_d         = StIdle;
      end
      StIdle: begin
        if (cfg_pend_q || cfg_load) begin
          cfg_pend_d = 1'b0;
          state_d    = StCfgDir;
        end else if (gpio_irq && !hold_q && !fifo_full) begin
          state_d = StRdAddr;
        end else if (out_req) begin
          state_d = StWrOut;
        end
      end
      StRdAddr: begin
        gpio_chipselect = 1'b1;
        gpio_address    = ADDR_CAP;
        state_d         = StRdData;
      end
      StRdData: begin
        cap_d    = gpio_readdata[GPIO_WIDTH-1:0];
        ts_cap_d = ts_q;
        // An all-zero capture means the irq was spurious: nothing to clear or log.
        state_d  = (|gpio_readdata[GPIO_WIDTH-1:0]) ? StClr : StIdle;
      end
      StClr: begin
        // Clear only the bits that were read; edges arriving since stay pending.
        gpio_chipselect = 1'b1;
        gpio_write_n    = 1'b0;
        gpio_address    = ADDR_CAP;
        gpio_writedata  = 32'(cap_q);
        push            = 1'b1;
        hold_d          = 1'b1;
        state_d         = StIdle;
      end
      StWrOut: begin
        gpio_chipselect = 1'b1;
        gpio_write_n    = 1'b0;
        gpio_address    = ADDR_DATA;
        gpio_writedata  = 32'(out_data);
        out_ack         = 1'b1;
        state_d         = StIdle;
      end
      default: begin
        state_d = StCfgDir;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  // Service is never started while full, so the guard on push is defensive only.
  assign push_en    = push && !fifo_full;
  assign pop        = evt_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q] <= {ts_cap_q, cap_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_valid = !fifo_empty;
  assign evt_count = count_q;
  assign evt_data  = fifo_empty ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_gpio_edge_service_ctrl.sv
// Bench for gpio_edge_service_ctrl: behavioural GPIO slave plus two scoreboards,
// one for bus operations and one for popped events.

module tb_gpio_edge_service_ctrl;

  localparam int unsigned GW    = 16;
  localparam int unsigned TW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     gpio_address;
  logic           gpio_chipselect;
  logic           gpio_write_n;
  logic [31:0]    gpio_writedata;
  logic [31:0]    gpio_readdata;
  logic           gpio_irq;
  logic [GW-1:0]  cfg_dir;
  logic [GW-1:0]  cfg_mask;
  logic           cfg_load;
  logic           out_req;
  logic [GW-1:0]  out_data;
  logic           out_ack;
  logic           evt_valid;
  logic           evt_ready;
  logic [TW+GW-1:0] evt_data;
  logic [CW-1:0]  evt_count;
  logic           busy;

  gpio_edge_service_ctrl #(
    .GPIO_WIDTH(GW),
    .TS_WIDTH  (TW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .gpio_address   (gpio_address),
    .gpio_chipselect(gpio_chipselect),
    .gpio_write_n   (gpio_write_n),
    .gpio_writedata (gpio_writedata),
    .gpio_readdata  (gpio_readdata),
    .gpio_irq       (gpio_irq),
    .cfg_dir        (cfg_dir),
    .cfg_mask       (cfg_mask),
    .cfg_load       (cfg_load),
    .out_req        (out_req),
    .out_data       (out_data),
    .out_ack        (out_ack),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_count      (evt_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // GPIO slave model
  // ---------------------------------------------------------------------------
  logic [GW-1:0] m_data, m_dir, m_mask, m_cap;
  logic [31:0]   m_rdata;
  logic [GW-1:0] edge_in;
  logic          spur;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data  <= '0;
      m_dir   <= '0;
      m_mask  <= '0;
      m_cap   <= '0;
      m_rdata <= '0;
    end else begin
      m_cap <= m_cap | edge_in;
      if (gpio_chipselect && !gpio_write_n) begin
        case (gpio_address)
          2'd0:    m_data <= gpio_writedata[GW-1:0];
          2'd1:    m_dir  <= gpio_writedata[GW-1:0];
          2'd2:    m_mask <= gpio_writedata[GW-1:0];
          default: m_cap  <= (m_cap & ~gpio_writedata[GW-1:0]) | edge_in;
        endcase
      end
      if (gpio_chipselect && gpio_write_n) begin
        case (gpio_address)
          2'd0:    m_rdata <= {16'h0, m_data};
          2'd1:    m_rdata <= {16'h0, m_dir};
          2'd2:    m_rdata <= {16'h0, m_mask};
          default: m_rdata <= spur ? 32'h0 : {16'h0, m_cap};
        endcase
      end
    end
  end

  assign gpio_readdata = m_rdata;
  assign gpio_irq      = (|(m_cap & m_mask)) | spur;

  logic [TW-1:0] tb_ts;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboards and monitor
  // ---------------------------------------------------------------------------
  logic [34:0] exp_bus [$];
  logic [31:0] exp_evt [$];
  localparam logic [34:0] BusRd = {1'b1, 2'd3, 32'd0};
  int ack_cnt = 0;

  function automatic logic [34:0] bus_wr(input logic [1:0] a, input logic [GW-1:0] d);
    return {1'b0, a, 16'h0, d};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (gpio_chipselect) begin
        check_eq("bus_pending", exp_bus.size() != 0, 1'b1);
        if (exp_bus.size() != 0)
          check_eq("bus_op", {gpio_write_n, gpio_address, gpio_writedata}, exp_bus.pop_front());
        if (!gpio_write_n && gpio_address == 2'd0)
          check_eq("ack_with_data_wr", out_ack, 1'b1);
      end
      if (out_ack) ack_cnt++;
      if (evt_valid && evt_ready) begin
        check_eq("evt_pending", exp_evt.size() != 0, 1'b1);
        if (exp_evt.size() != 0) check_eq("evt_data", evt_data, exp_evt.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the edge lands in the slave on the next one.
  task automatic inject(input logic [GW-1:0] bits, input bit expect_evt);
    edge_in = bits;
    if (expect_evt) begin
      exp_bus.push_back(BusRd);
      exp_bus.push_back(bus_wr(2'd3, bits));
      exp_evt.push_back({tb_ts + 16'd3, bits});
    end
    step(1);
    edge_in = '0;
  endtask

  initial begin
    int a0;
    int k;
    reset     = 1'b1;
    cfg_dir   = 16'h00FF;
    cfg_mask  = 16'hFF00;
    cfg_load  = 1'b0;
    out_req   = 1'b0;
    out_data  = '0;
    evt_ready = 1'b1;
    edge_in   = '0;
    spur      = 1'b0;
    step(3);

    // Reset values
    check_eq("rst_cs", gpio_chipselect, 1'b0);
    check_eq("rst_write_n", gpio_write_n, 1'b1);
    check_eq("rst_addr", gpio_address, 2'd0);
    check_eq("rst_wdata", gpio_writedata, 32'd0);
    check_eq("rst_ack", out_ack, 1'b0);
    check_eq("rst_valid", evt_valid, 1'b0);
    check_eq("rst_evt_data", evt_data, 32'd0);
    check_eq("rst_count", evt_count, 4'd0);
    check_eq("rst_busy", busy, 1'b1);

    // Reset release: dir, mask, then idle
    exp_bus.push_back(bus_wr(2'd1, 16'h00FF));
    exp_bus.push_back(bus_wr(2'd2, 16'hFF00));
    reset = 1'b0;
    step(1);
    check_eq("cfg_cycle1", {gpio_chipselect, gpio_write_n, gpio_address, gpio_writedata},
             {1'b1, 1'b0, 2'd1, 32'h0000_00FF});
    step(1);
    check_eq("cfg_cycle2", {gpio_chipselect, gpio_write_n, gpio_address, gpio_writedata},
             {1'b1, 1'b0, 2'd2, 32'h0000_FF00});
    step(1);
    check_eq("cfg_cycle3_busy", busy, 1'b0);
    check_eq("slave_dir", m_dir, 16'h00FF);
    step(2);

    // Single edge
    evt_ready = 1'b0;
    inject(16'h0100, 1'b1);
    step(5);
    check_eq("single_count", evt_count, 4'd1);
    check_eq("single_irq_low", gpio_irq, 1'b0);
    evt_ready = 1'b1;
    step(2);
    check_eq("single_drained", evt_count, 4'd0);

    // Contention: irq and out_req in the same cycle
    a0 = ack_cnt;
    inject(16'h0200, 1'b1);
    out_req  = 1'b1;
    out_data = 16'h00A5;
    exp_bus.push_back(bus_wr(2'd0, 16'h00A5));
    k = 0;
    while (!out_ack && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("ack_seen", out_ack, 1'b1);
    @(posedge clk);
    #1;
    out_req = 1'b0;
    step(4);
    check_eq("ack_pulses", ack_cnt - a0, 1);
    check_eq("slave_data", m_data, 16'h00A5);

    // FIFO full: eight entries, then service stalls until a pop
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inject(16'h0100 << i, 1'b1);
      step(6);
    end
    check_eq("full_count", evt_count, 4'd8);
    inject(16'h0100, 1'b0);
    step(3);
    inject(16'h0200, 1'b0);
    step(8);
    check_eq("full_hold_count", evt_count, 4'd8);
    check_eq("full_idle", busy, 1'b0);
    check_eq("full_irq_pending", gpio_irq, 1'b1);
    exp_bus.push_back(BusRd);
    exp_bus.push_back(bus_wr(2'd3, 16'h0300));
    exp_evt.push_back({tb_ts + 16'd3, 16'h0300});
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    step(6);
    check_eq("merged_count", evt_count, 4'd8);
    evt_ready = 1'b1;
    step(10);
    check_eq("full_drained", evt_count, 4'd0);

    // Spurious irq: read returns zero, no clear, no push
    spur = 1'b1;
    exp_bus.push_back(BusRd);
    step(2);
    spur = 1'b0;
    step(4);
    check_eq("spur_count", evt_count, 4'd0);
    check_eq("spur_idle", busy, 1'b0);

    // Timestamp wrap in the pushed event
    k = 0;
    while (tb_ts != 16'hFFFD && k < 70000) begin
      step(1);
      k++;
    end
    check_eq("wrap_reached", tb_ts, 16'hFFFD);
    inject(16'h0400, 1'b1);
    step(6);
    check_eq("wrap_drained", evt_count, 4'd0);

    // cfg_load during CLR: clear and push finish, then reconfiguration
    cfg_dir  = 16'h0F0F;
    cfg_mask = 16'hF0F0;
    inject(16'h0800, 1'b1);
    exp_bus.push_back(bus_wr(2'd1, 16'h0F0F));
    exp_bus.push_back(bus_wr(2'd2, 16'hF0F0));
    step(3);
    check_eq("clr_cycle_cs", {gpio_chipselect, gpio_write_n, gpio_address}, {1'b1, 1'b0, 2'd3});
    cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
    step(6);
    check_eq("reload_idle", busy, 1'b0);
    check_eq("slave_mask", m_mask, 16'hF0F0);

    // Reset during RD_DATA flushes the FIFO
    evt_ready = 1'b0;
    inject(16'h1000, 1'b1);
    step(6);
    check_eq("pre_rst_count", evt_count, 4'd1);
    exp_bus.push_back(BusRd);
    inject(16'h2000, 1'b0);
    step(2);
    check_eq("in_rd_data_busy", busy, 1'b1);
    reset = 1'b1;
    exp_evt.delete();
    #1;
    check_eq("mid_rst_count", evt_count, 4'd0);
    check_eq("mid_rst_valid", evt_valid, 1'b0);
    check_eq("mid_rst_cs", gpio_chipselect, 1'b0);
    step(2);
    exp_bus.push_back(bus_wr(2'd1, 16'h0F0F));
    exp_bus.push_back(bus_wr(2'd2, 16'hF0F0));
    reset     = 1'b0;
    evt_ready = 1'b1;
    step(6);
    check_eq("post_rst_idle", busy, 1'b0);
    check_eq("post_rst_count", evt_count, 4'd0);

    check_eq("bus_sb_empty", exp_bus.size(), 0);
    check_eq("evt_sb_empty", exp_evt.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
